// File: rtl/cpu_player_pkg.sv
// Shared types and constants for the computer tug-of-war opponent.
package cpu_player_pkg;

  // Opponent controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  // Width of the pseudo-random decision register.
  localparam int LFSR_W = 10;

  // Width of the aggressiveness setting (probability = difficulty / 512).
  localparam int DIFF_W = 9;

  // Feedback taps for x^10 + x^7 + 1: register bits 9 and 6.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'b10_0100_0000;

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR that shifts toward the MSB, advancing only when asked.
// An all-zero register can never escape on its own, so the next advance
// from zero reloads the seed.
module lfsr_gen
  import cpu_player_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(10'h1A5)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  // A zero seed would lock the register up, so substitute 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS);

  logic [WIDTH-1:0] shift_q;

  // Shift register: reseed on reset or lock-up, otherwise step on advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= SEED_EFF;
    end else if (advance) begin
      if (shift_q == '0) begin
        shift_q <= SEED_EFF;
      end else begin
        shift_q <= {shift_q[WIDTH-2:0], ^(shift_q & TAPS)};
      end
    end
  end

  assign value = shift_q;

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: on every slow decision tick it compares a random number
// against the difficulty switches and, on a hit, emits a one-cycle pull pulse
// followed by a cooldown of whole ticks.
module cpu_player
  import cpu_player_pkg::*;
#(
  parameter int                TICK_PERIOD    = 1048576,
  parameter int                COOLDOWN_TICKS = 2,
  parameter logic [LFSR_W-1:0] SEED           = 10'h1A5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIFF_W-1:0] difficulty,
  output logic              pull,
  output logic              busy
);

  localparam int CNT_W = (TICK_PERIOD < 2) ? 1 : $clog2(TICK_PERIOD);
  localparam int CD_W  = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0]  prescale;
  logic [CD_W-1:0]   cd_cnt;
  logic [LFSR_W-1:0] rand_value;
  logic              tick;
  logic              fire;
  state_t            state;

  // The tick only exists while the opponent is active.
  assign tick = enable && (prescale == CNT_LAST);

  // The decision uses the value before this tick's advance.
  assign fire = (rand_value[DIFF_W-1:0] < difficulty);

  // Prescaler: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      prescale <= '0;
    end else if (prescale == CNT_LAST) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + CNT_W'(1);
    end
  end

  lfsr_gen #(
    .WIDTH (LFSR_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (tick),
    .value   (rand_value)
  );

  // Controller: decide on ticks, pulse for one cycle, then sit out whole ticks.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      state  <= IDLE;
      pull   <= 1'b0;
      busy   <= 1'b0;
      cd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && fire) begin
            state <= FIRE;
            pull  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        FIRE: begin
          pull <= 1'b0;
          if (COOLDOWN_TICKS == 0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= COOLDOWN;
            busy   <= 1'b1;
            cd_cnt <= CD_W'(COOLDOWN_TICKS);
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cd_cnt == CD_W'(1)) begin
              state  <= IDLE;
              busy   <= 1'b0;
              cd_cnt <= '0;
            end else begin
              cd_cnt <= cd_cnt - CD_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          pull   <= 1'b0;
          busy   <= 1'b0;
          cd_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_player.sv
// Scoreboard bench for cpu_player: a driver steps a reference model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_cpu_player;

  localparam int         TP   = 4;
  localparam int         COOL = 2;
  localparam logic [9:0] SEED = 10'h1A5;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] difficulty;
  logic       pull;
  logic       busy;

  cpu_player #(
    .TICK_PERIOD    (TP),
    .COOLDOWN_TICKS (COOL),
    .SEED           (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .difficulty (difficulty),
    .pull       (pull),
    .busy       (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit pull;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit prev_pull = 1'b0;

  int m_phase = 0;
  int m_lfsr  = 0;
  int m_cool  = 0;
  bit m_pull  = 1'b0;
  bit m_busy  = 1'b0;

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic int lfsr_step(input int v);
    int b;
    if (v == 0) return int'(SEED);
    b = ((v >> 9) ^ (v >> 6)) & 1;
    return ((v << 1) | b) & 'h3FF;
  endfunction

  // Reference model: one clock edge, expressed as "ticks every TP cycles,
  // random draw below difficulty fires, then COOL ticks of rest".
  task automatic model_step(input bit r, input bit e, input int d);
    bit t;
    bit new_pull;
    if (!r) begin
      m_phase = 0; m_lfsr = int'(SEED); m_cool = 0; m_pull = 0; m_busy = 0;
    end else if (!e) begin
      m_phase = 0; m_cool = 0; m_pull = 0; m_busy = 0;
    end else begin
      t = (m_phase == TP - 1);
      m_phase = t ? 0 : m_phase + 1;
      new_pull = 1'b0;
      if (m_pull) begin
        m_cool = COOL;
      end else if (t) begin
        if (m_cool > 0) m_cool--;
        else if ((m_lfsr & 'h1FF) < (d & 'h1FF)) new_pull = 1'b1;
      end
      if (t) m_lfsr = lfsr_step(m_lfsr);
      m_pull = new_pull;
      m_busy = m_pull || (m_cool > 0);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input int d, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      reset      = r;
      enable     = e;
      difficulty = d[8:0];
      @(posedge clk);
      #1;
      cyc++;
      model_step(r, e, d);
      x.cyc  = cyc;
      x.pull = m_pull;
      x.busy = m_busy;
      exp_q.push_back(x);
      if (m_pull) pulse_q.push_back(cyc);
      checkOutput("lfsr", int'(dut.u_lfsr.value), m_lfsr);
    end
  endtask

  // Monitor: compare every presented cycle and every pull pulse.
  always @(negedge clk) begin
    exp_t e;
    int want_cyc;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("pull", int'(pull), int'(e.pull));
      checkOutput("busy", int'(busy), int'(e.busy));
      if (pull) begin
        want_cyc = (pulse_q.size() > 0) ? pulse_q.pop_front() : -1;
        checkOutput("pulse_cycle", cyc, want_cyc);
        checkOutput("pulse_width", int'(prev_pull), 0);
      end
      prev_pull = pull;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int saved;
    int zero_seen;
    int len;
    int d;
    bit r;
    bit e;

    reset = 1'b0; enable = 1'b1; difficulty = 9'h0;

    // Reset with enable high.
    applyStimulus(0, 1, $urandom_range(0, 511), 2);
    checkOutput("reset_lfsr", int'(dut.u_lfsr.value), int'(SEED));

    // Difficulty zero never fires; LFSR keeps stepping once per tick.
    applyStimulus(1, 1, 0, 200);

    // Maximum difficulty: pulses every tick period times (1 + cooldown).
    applyStimulus(1, 1, 'h1FF, 100);

    // Drop enable in the middle of a cooldown.
    n = 0;
    while (!(m_cool > 0 && !m_pull) && n < 100) begin
      applyStimulus(1, 1, 'h1FF, 1);
      n++;
    end
    checkOutput("reach_cooldown", int'(n < 100), 1);
    saved = m_lfsr;
    applyStimulus(1, 0, 'h1FF, 6);
    checkOutput("lfsr_frozen", int'(dut.u_lfsr.value), saved);
    applyStimulus(1, 1, 'h1FF, 10);

    // Reset asserted while the pulse is on the output.
    n = 0;
    while (!m_pull && n < 100) begin
      applyStimulus(1, 1, 'h1FF, 1);
      n++;
    end
    checkOutput("reach_fire", int'(n < 100), 1);
    applyStimulus(0, 1, 'h1FF, 1);
    checkOutput("rst_fire_lfsr", int'(dut.u_lfsr.value), int'(SEED));
    applyStimulus(1, 1, 'h1FF, TP);

    // Full LFSR period from the seed with no pulses.
    applyStimulus(0, 1, 0, 1);
    zero_seen = 0;
    for (int i = 0; i < 1023 * TP; i++) begin
      applyStimulus(1, 1, 0, 1);
      if (dut.u_lfsr.value == 10'h0) zero_seen++;
    end
    checkOutput("lfsr_nonzero", zero_seen, 0);
    checkOutput("lfsr_period", int'(dut.u_lfsr.value), int'(SEED));

    // Randomised segments of enable, reset and difficulty.
    for (int s = 0; s < 200; s++) begin
      r = ($urandom_range(0, 39) != 0);
      e = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0:       d = 0;
        1:       d = 'h1FF;
        default: d = $urandom_range(0, 511);
      endcase
      len = $urandom_range(1, 20);
      applyStimulus(r, e, d, len);
    end

    // Lock-up recovery: force the register to zero, then let it advance.
    applyStimulus(1, 0, 0, 2);
    force dut.u_lfsr.shift_q = 10'h0;
    m_lfsr = 0;
    applyStimulus(1, 0, 0, 1);
    release dut.u_lfsr.shift_q;
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, TP);
    checkOutput("zero_recover", int'(dut.u_lfsr.value), int'(SEED));

    // Drain and finish.
    applyStimulus(1, 0, 0, 2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pulses_pending", pulse_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Computer opponent for the tug-of-war game: generates one-cycle pull pulses on the same contract as a debounced human button path (one pulse per press, never two consecutive cycles high).
- Top level muxes its pull output into the right-player pull net in place of the human right-button path when single-player mode is selected.
- Aggressiveness is set by switches; pull decisions come from an LFSR sampled on a slow prescaled tick.

Parameters:
- TICK_PERIOD, 1048576, clock cycles per decision tick (~21 ms at 50 MHz); minimum 2.
- COOLDOWN_TICKS, 2, ticks after a pulse during which no decision is made; 0 allowed.
- SEED, 10'h1A5, LFSR reset value; a value of 0 is replaced by 10'h001.

Ports:
- clk, input, 1, system clock (CLOCK_50 at top).
- reset, input, 1, synchronous, active-low reset; 0 = reset. Top connects KEY[1] directly.
- enable, input, 1, opponent active; top drives SW[9] & ~game_over.
- difficulty, input, 9, pull probability per tick = difficulty/512; top drives SW[8:0].
- pull, output, 1, registered one-cycle pull pulse.
- busy, output, 1, registered; high when state is not IDLE.

Behaviour:
- **Reset** (reset==0 at a posedge), dominates all other inputs:
  - state=IDLE, pull=0, busy=0;
  - prescaler=0, cooldown count=0, lfsr=SEED.
- **Prescaler:**
  - Counts 0..TICK_PERIOD-1 and wraps to 0.
  - tick = enable && (count==TICK_PERIOD-1); combinational, internal.
  - Held at 0 while enable==0.
- **LFSR:**
  - 10-bit Fibonacci, polynomial x^10+x^7+1, XOR feedback, shifts toward the MSB.
  - Advances exactly once per tick; holds otherwise, including while enable==0.
  - If the register is ever all-zero, the next advance loads SEED.
  - Period is 1023.
- **Decision:** fire = (lfsr[8:0] < difficulty), using the pre-advance LFSR value on the tick edge.
  - difficulty is not latched; the value present at the tick edge is used.
  - difficulty=0 never fires.
- **FSM** (states IDLE, FIRE, COOLDOWN):
  - IDLE: tick && fire -> FIRE; otherwise stay.
  - FIRE: lasts exactly one cycle. Goes to COOLDOWN with count=COOLDOWN_TICKS; if COOLDOWN_TICKS==0, goes to IDLE.
  - COOLDOWN: count decrements on each tick. On the tick where count==1, go to IDLE. That tick evaluates no decision, but the LFSR still advances.
  - enable==0: next state IDLE from any state; cooldown count cleared.
- **Outputs:**
  - pull = (state==FIRE); busy = (state!=IDLE).
  - Latency: tick edge with fire -> pull high for the following full cycle.
  - pull is never high two consecutive cycles.
  - With continuous firing, the pulse spacing is TICK_PERIOD*(1+COOLDOWN_TICKS) cycles.
- **Reset mid-operation:** reset asserted during FIRE or COOLDOWN gives pull=0 and busy=0 the next cycle. No pulse follows until a full TICK_PERIOD after reset release.

Decomposition:
- Package cpu_player_pkg:
  - state enum typedef {IDLE, FIRE, COOLDOWN};
  - LFSR_W=10;
  - tap constant (bits 9,6);
  - DIFF_W=9.
- Sub-module lfsr_gen (params WIDTH, SEED; ports clk, reset, advance, value) holds the LFSR and the zero-lockup recovery.
- Prescaler and FSM stay in cpu_player.

Test Plan (TICK_PERIOD=4, COOLDOWN_TICKS=2, SEED=10'h1A5):
- reset=0 for 2 cycles with enable=1 -> pull=0, busy=0, internal lfsr=10'h1A5.
- enable=1, difficulty=0 for 200 cycles -> pull never 1; lfsr advances every 4th cycle (50 advances), matching the bench software model.
- difficulty=9'h1FF, enable=1 -> every pull pulse is exactly 1 cycle wide; pulses are spaced 12 cycles apart except at ticks where lfsr[8:0]==9'h1FF; busy high from pulse through cooldown.
- enable dropped in COOLDOWN -> busy=0 next cycle, no pull, lfsr frozen; after re-enable the first decision occurs 4 cycles later.
- reset=0 asserted in the FIRE cycle -> pull=0 next cycle, lfsr=SEED; no pulse within 4 cycles of release.
- difficulty=0, 1023 ticks -> lfsr returns to 10'h1A5 and is never 0 in between; forcing lfsr to 0 -> next advance yields 10'h1A5.
